// File: rtl/cp_strip_rev.sv
`default_nettype none
// ============================================================================
// cp_strip_rev : drops the cyclic prefix of each OFDM symbol and applies a
//                per-symbol (-1)^k sign alternation to the N_FFT body samples.
// Revision 1.0
// ============================================================================
module cp_strip_rev #(
  parameter int W      = 20,
  parameter int N_FFT  = 64,
  parameter int CP_LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic         in_sop,
  input  logic [W-1:0] in_i,
  input  logic [W-1:0] in_q,
  output logic [W-1:0] out_i,
  output logic [W-1:0] out_q,
  output logic         out_valid,
  output logic         sop_out,
  output logic         eop_out,
  output logic         sym_err
);

  localparam int KW = (N_FFT > 1) ? $clog2(N_FFT) : 1;
  localparam int PW = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_FFT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(CP_LEN - 1);
  localparam logic [W-1:0]  S_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  S_MAX  = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [W-1:0]  i_nxt, q_nxt;
  logic          valid_nxt, sop_nxt, eop_nxt, err_nxt;
  logic          accept;

  assign accept = en & in_valid;

  // The most negative value has no positive twin; clip it to the maximum.
  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] x);
    return (x == S_MIN) ? S_MAX : (-x);
  endfunction

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    k_nxt     = k;
    i_nxt     = out_i;
    q_nxt     = out_q;
    valid_nxt = 1'b0;
    sop_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (accept) begin
      if (in_sop) begin
        // A start marker always opens a new symbol, abandoning any in flight.
        err_nxt = (state != IDLE);
        k_nxt   = '0;
        if (P_LAST == '0) begin
          state_nxt = BODY;
          pcnt_nxt  = '0;
        end else begin
          state_nxt = CP;
          pcnt_nxt  = PW'(1);
        end
      end else begin
        case (state)
          IDLE: ;
          CP: begin
            if (pcnt == P_LAST) begin
              state_nxt = BODY;
              pcnt_nxt  = '0;
            end else begin
              pcnt_nxt = pcnt + PW'(1);
            end
          end
          BODY: begin
            valid_nxt = 1'b1;
            sop_nxt   = (k == '0);
            eop_nxt   = (k == K_LAST);
            i_nxt     = k[0] ? neg_sat(in_i) : in_i;
            q_nxt     = k[0] ? neg_sat(in_q) : in_q;
            if (k == K_LAST) begin
              state_nxt = IDLE;
              k_nxt     = '0;
            end else begin
              k_nxt = k + KW'(1);
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      k         <= '0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      sym_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pcnt      <= pcnt_nxt;
      k         <= k_nxt;
      out_i     <= i_nxt;
      out_q     <= q_nxt;
      out_valid <= valid_nxt;
      sop_out   <= sop_nxt;
      eop_out   <= eop_nxt;
      sym_err   <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cp_strip_rev.sv
`default_nettype none
// Testbench for cp_strip_rev: directed scenarios plus random traffic, all
// checked cycle by cycle against a symbol-position reference model.
module tb_cp_strip_rev;

  localparam int W      = 20;
  localparam int N_FFT  = 64;
  localparam int CP_LEN = 16;
  localparam int SMAX   = 2**(W-1) - 1;
  localparam int SMIN   = -(2**(W-1));

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sop = 1'b0;
  logic [W-1:0] in_i = '0;
  logic [W-1:0] in_q = '0;
  logic [W-1:0] out_i, out_q;
  logic         out_valid, sop_out, eop_out, sym_err;

  cp_strip_rev #(.W(W), .N_FFT(N_FFT), .CP_LEN(CP_LEN)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sop(in_sop),
    .in_i(in_i), .in_q(in_q), .out_i(out_i), .out_q(out_q),
    .out_valid(out_valid), .sop_out(sop_out), .eop_out(eop_out), .sym_err(sym_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pos = samples already taken in the current symbol, -1 when idle.
  int pos = -1;
  int e_i = 0, e_q = 0;
  bit e_v = 0, e_s = 0, e_e = 0, e_r = 0;

  int cap_i[$], cap_q[$], ref_i[$], ref_q[$];
  bit cap_s[$], cap_e[$];
  int err_pulses = 0, eop_pulses = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nsat(input int x);
    return (x == SMIN) ? SMAX : -x;
  endfunction

  task automatic model_reset();
    pos = -1;
    e_v = 0; e_s = 0; e_e = 0; e_r = 0;
    e_i = 0; e_q = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input bit s, input int i, input int q);
    int kk;
    e_v = 0; e_s = 0; e_e = 0; e_r = 0;
    if (e && v) begin
      if (s) begin
        e_r = (pos >= 0);
        pos = 1;
      end else if (pos >= 0) begin
        if (pos < CP_LEN) begin
          pos++;
        end else begin
          kk  = pos - CP_LEN;
          e_v = 1;
          e_s = (kk == 0);
          e_e = (kk == N_FFT - 1);
          e_i = (kk % 2 == 1) ? nsat(i) : i;
          e_q = (kk % 2 == 1) ? nsat(q) : q;
          pos = e_e ? -1 : pos + 1;
        end
      end
    end
  endtask

  task automatic compare();
    check("out_valid", {63'd0, out_valid}, {63'd0, e_v});
    check("sop_out", {63'd0, sop_out}, {63'd0, e_s});
    check("eop_out", {63'd0, eop_out}, {63'd0, e_e});
    check("sym_err", {63'd0, sym_err}, {63'd0, e_r});
    check("out_i", $signed(out_i), e_i);
    check("out_q", $signed(out_q), e_q);
    if (out_valid === 1'b1) begin
      cap_i.push_back($signed(out_i));
      cap_q.push_back($signed(out_q));
      cap_s.push_back(sop_out);
      cap_e.push_back(eop_out);
    end
    if (sym_err === 1'b1) err_pulses++;
    if (eop_out === 1'b1) eop_pulses++;
  endtask

  task automatic cyc(input bit e, input bit v, input bit s, input int i, input int q);
    en = e; in_valid = v; in_sop = s;
    in_i = W'(i); in_q = W'(q);
    @(posedge clk);
    if (!rst) model_reset();
    else model_step(e, v, s, i, q);
    #1;
    compare();
  endtask

  task automatic clear_caps();
    cap_i.delete(); cap_q.delete(); cap_s.delete(); cap_e.delete();
    err_pulses = 0; eop_pulses = 0;
  endtask

  task automatic send_sym();
    for (int n = 0; n < CP_LEN + N_FFT; n++) cyc(1, 1, n == 0, n, -n);
  endtask

  int ri, rq;
  logic [W-1:0] tmp;
  bit rs;

  initial begin
    // Reset state
    #1;
    model_reset();
    compare();
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 5, 5);
    rst = 1'b1;

    // Single symbol, continuous valid
    clear_caps();
    send_sym();
    cyc(0, 0, 0, 0, 0);
    check("s1_count", cap_i.size(), 64);
    check("s1_o0_i", cap_i[0], 16);
    check("s1_o0_q", cap_q[0], -16);
    check("s1_o0_sop", {63'd0, cap_s[0]}, 1);
    check("s1_o1_i", cap_i[1], -17);
    check("s1_o1_q", cap_q[1], 17);
    check("s1_o63_i", cap_i[63], -79);
    check("s1_o63_q", cap_q[63], 79);
    check("s1_o63_eop", {63'd0, cap_e[63]}, 1);
    check("s1_err", err_pulses, 0);
    ref_i = cap_i;
    ref_q = cap_q;

    // Same symbol with toggling valid and an enable stall mid-body
    clear_caps();
    for (int n = 0; n < CP_LEN + N_FFT; n++) begin
      cyc(1, 1, n == 0, n, -n);
      cyc(1, 0, 0, 777, 777);
      if (n == 40) repeat (5) cyc(0, 1, 0, 999, 999);
    end
    check("s2_count", cap_i.size(), 64);
    for (int j = 0; j < 64; j++) begin
      check("s2_i", cap_i[j], ref_i[j]);
      check("s2_q", cap_q[j], ref_q[j]);
    end

    // Back-to-back symbols
    clear_caps();
    send_sym();
    send_sym();
    cyc(0, 0, 0, 0, 0);
    check("s3_count", cap_i.size(), 128);
    check("s3_k0_i", cap_i[64], 16);
    check("s3_k0_sop", {63'd0, cap_s[64]}, 1);
    check("s3_eops", eop_pulses, 2);

    // Resync at body k=30
    clear_caps();
    for (int n = 0; n < CP_LEN + 30; n++) cyc(1, 1, n == 0, n, -n);
    send_sym();
    cyc(0, 0, 0, 0, 0);
    check("s4_count", cap_i.size(), 94);
    check("s4_err", err_pulses, 1);
    check("s4_eops", eop_pulses, 1);
    check("s4_k29_eop", {63'd0, cap_e[29]}, 0);
    check("s4_sop", {63'd0, cap_s[30]}, 1);
    check("s4_k0_i", cap_i[30], 16);
    check("s4_last_eop", {63'd0, cap_e[93]}, 1);

    // Saturating negation at odd k
    clear_caps();
    for (int n = 0; n < CP_LEN + N_FFT; n++) begin
      if (n == CP_LEN + 1) cyc(1, 1, 0, SMIN, SMAX);
      else cyc(1, 1, n == 0, n, -n);
    end
    cyc(0, 0, 0, 0, 0);
    check("s5_i", cap_i[1], SMAX);
    check("s5_q", cap_q[1], -SMAX);

    // Asynchronous reset mid-body, then restart
    for (int n = 0; n <= CP_LEN + 10; n++) cyc(1, 1, n == 0, n, -n);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare();
    cyc(1, 1, 0, 3, 3);
    cyc(1, 1, 1, 4, 4);
    rst = 1'b1;
    clear_caps();
    for (int n = 0; n < 3; n++) cyc(1, 1, 0, 100 + n, 100 + n);
    send_sym();
    cyc(0, 0, 0, 0, 0);
    check("s6_count", cap_i.size(), 64);
    check("s6_sop", {63'd0, cap_s[0]}, 1);
    check("s6_k0_i", cap_i[0], 16);
    check("s6_eops", eop_pulses, 1);
    check("s6_err", err_pulses, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if (pos < 0) rs = ($urandom_range(0, 3) == 0);
      else rs = ($urandom_range(0, 199) == 0);
      tmp = W'($urandom);
      ri = (($urandom_range(0, 15) == 0) ? SMIN : int'($signed(tmp)));
      tmp = W'($urandom);
      rq = (($urandom_range(0, 15) == 0) ? SMIN : int'($signed(tmp)));
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, rs, ri, rq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp_strip_rev.md
Name: cp_strip_rev

Overview:
- Receive-side counterpart of the transmit cyclic-prefix/spectrum-reversal path.
- Takes a framed OFDM sample stream in which each symbol is CP_LEN prefix samples followed by N_FFT body samples. Discards the prefix and forwards the N_FFT body samples to the FFT input.
- Applies the (-1)^k spectrum-reversal sign alternation to the body samples. The alternation restarts at k=0 on every symbol, so the FFT bin mapping is always aligned to the symbol.
- Emits symbol framing (sop/eop) and a resync error pulse.

Parameters:
- W, 20: sample width in bits, signed two's complement, for both I and Q.
- N_FFT, 64: body (useful) samples per symbol. Legal range 2..1024.
- CP_LEN, 16: cyclic-prefix samples per symbol. Legal range 1..N_FFT.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; input is sampled only when en=1.
- in_valid  in  1  input sample qualifier.
- in_sop  in  1  marks the first CP sample of a symbol; meaningful only with in_valid=1.
- in_i  in  W  signed I sample.
- in_q  in  W  signed Q sample.
- out_i  out  W  signed I, sign-alternated body sample.
- out_q  out  W  signed Q, sign-alternated body sample.
- out_valid  out  1  output sample qualifier.
- sop_out  out  1  first body sample of a symbol (k=0).
- eop_out  out  1  last body sample of a symbol (k=N_FFT-1).
- sym_err  out  1  one-cycle pulse when in_sop arrives mid-symbol.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0.
  - FSM goes to IDLE; the position counter and k counter go to 0.
- Accepted sample: a clock edge with rst=1, en=1, in_valid=1. With en=0 or in_valid=0, nothing changes except that out_valid, sop_out, eop_out and sym_err drop to 0 on the next edge. out_i/out_q hold their last value.
- FSM states:
  - IDLE: waiting for in_sop. Accepted samples without in_sop are dropped silently.
  - CP: counting prefix samples.
  - BODY: forwarding body samples.
- FSM transitions:
  - IDLE + accepted in_sop → CP. That sample is prefix index 0.
  - CP: the prefix counter increments per accepted sample. The accepted sample at index CP_LEN-1 moves the FSM to BODY.
  - BODY: the k counter (0..N_FFT-1) increments per accepted sample. The accepted sample at k=N_FFT-1 moves the FSM to IDLE and clears k.
- Prefix samples never produce output.
- Output timing:
  - Each accepted BODY sample produces out_valid=1 exactly 1 cycle later (registered outputs, latency 1).
  - sop_out=1 with k=0; eop_out=1 with k=N_FFT-1.
  - sop_out and eop_out are never asserted without out_valid.
- Sign rule:
  - k even: out = in.
  - k odd: out = -in, for both I and Q independently.
  - Negation saturates: -(-2^(W-1)) gives 2^(W-1)-1. No other value clips.
- Resync: an accepted in_sop while in CP or BODY:
  - The current symbol is abandoned; no eop_out is issued for it.
  - The FSM enters CP with this sample as prefix index 0; k is cleared.
  - sym_err=1 for one cycle, 1 cycle after the sample.
  - Output already emitted stays as emitted.
- in_sop on the sample that would end BODY (k=N_FFT-1) is also a resync: no eop_out, sym_err pulses, and the sample counts as prefix index 0.
- Back-to-back symbols with no gap are supported: the next in_sop may arrive on the cycle after the last body sample.
- Reset asserted mid-symbol aborts immediately (asynchronous). After release, the block waits in IDLE for a fresh in_sop.
- Counter widths are clog2(N_FFT) for k and clog2(CP_LEN) for the prefix counter, minimum 1. Counters never wrap except through the explicit returns described above.

Test Plan:
- Reset then one symbol of 80 samples (CP=16, N=64), in_valid=1 every cycle, in_i=n (sample index), in_q=-n → exactly 64 outputs. Output 0 is 16 with sop_out=1 and q=-16. Output 1 is i=-17, q=17. Output 63 is i=-79, q=79 with eop_out=1. Latency is 1 cycle; sym_err stays 0 throughout.
- Same symbol with in_valid toggling 1/0 and en forced low for 5 cycles mid-body → identical 64 output values in order; out_valid is 0 on every stalled cycle.
- Two back-to-back symbols, second in_sop on the cycle right after the first eop → the second symbol's k=0 output is positive, i.e. the alternation restarts.
- in_sop injected at body k=30 → no eop_out for the first symbol, sym_err pulses once, and the next 64 outputs after 16 prefix samples are framed correctly.
- Body sample at odd k with in_i=-524288, in_q=524287 → out_i=524287, out_q=-524287.
- rst driven low at body k=10, then released; 3 non-sop samples followed by a full symbol → the 3 samples are dropped, the full symbol is output normally, and all outputs read 0 during reset.
